// File: rtl/sfx_scheduler_if.sv
// Bundle between the game event sources and the sound-effect scheduler:
// event pulses, frame tick and mute in; tone-generator drive and status out.
interface sfx_scheduler_if;
  logic       startOfFrame;
  logic       ev_gold;
  logic       ev_alien;
  logic       ev_died;
  logic       ev_win;
  logic       ev_over;
  logic       mute;
  logic       tone_en;
  logic [3:0] tone_code;
  logic [2:0] sfx_id;
  logic       busy;

  modport master (
    output startOfFrame, ev_gold, ev_alien, ev_died, ev_win, ev_over, mute,
    input  tone_en, tone_code, sfx_id, busy
  );

  modport slave (
    input  startOfFrame, ev_gold, ev_alien, ev_died, ev_win, ev_over, mute,
    output tone_en, tone_code, sfx_id, busy
  );
endinterface

// File: rtl/sfx_scheduler.sv
// Shares one tone generator between game sound effects: latches event pulses,
// arbitrates by fixed priority with preemption, and plays frame-timed note sequences.
module sfx_scheduler #(
  parameter int NOTE_FRAMES = 4,
  parameter int GAP_FRAMES  = 2
) (
  input  logic            clk,
  input  logic            resetN,
  sfx_scheduler_if.slave  bus
);

  localparam logic [3:0] NOTE_LAST = 4'(NOTE_FRAMES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t     state_r;
  logic [4:0] pending_r;
  logic [3:0] frame_cnt_r;
  logic [1:0] step_r;
  logic       tone_en_r;
  logic [3:0] tone_code_r;
  logic [2:0] sfx_id_r;
  logic       busy_r;

  logic [4:0] ev_s;
  logic [2:0] hi_id_s;
  logic       load_s;
  logic [4:0] clr_mask_s;

  // Note table indexed by {effect id, step}; unused slots read as silence.
  function automatic logic [3:0] note_of(input logic [2:0] id, input logic [1:0] step);
    logic [3:0] n;
    case ({id, step})
      5'b001_00: n = 4'd5;
      5'b001_01: n = 4'd8;
      5'b010_00: n = 4'd9;
      5'b010_01: n = 4'd6;
      5'b010_10: n = 4'd3;
      5'b011_00: n = 4'd7;
      5'b011_01: n = 4'd5;
      5'b011_10: n = 4'd3;
      5'b011_11: n = 4'd1;
      5'b100_00: n = 4'd1;
      5'b100_01: n = 4'd3;
      5'b100_10: n = 4'd5;
      5'b100_11: n = 4'd8;
      5'b101_00: n = 4'd8;
      5'b101_01: n = 4'd6;
      5'b101_10: n = 4'd4;
      5'b101_11: n = 4'd2;
      default:   n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] last_step_of(input logic [2:0] id);
    logic [1:0] s;
    case (id)
      3'd1:    s = 2'd1;
      3'd2:    s = 2'd2;
      3'd3:    s = 2'd3;
      3'd4:    s = 2'd3;
      3'd5:    s = 2'd3;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

  assign ev_s = {bus.ev_over, bus.ev_win, bus.ev_died, bus.ev_alien, bus.ev_gold};

  // Fixed-priority pick of the highest pending effect (0 when none pending).
  always_comb begin
    hi_id_s = 3'd0;
    if (pending_r[4]) begin
      hi_id_s = 3'd5;
    end else if (pending_r[3]) begin
      hi_id_s = 3'd4;
    end else if (pending_r[2]) begin
      hi_id_s = 3'd3;
    end else if (pending_r[1]) begin
      hi_id_s = 3'd2;
    end else if (pending_r[0]) begin
      hi_id_s = 3'd1;
    end else begin
      hi_id_s = 3'd0;
    end
  end

  // Load decision: start from idle, or preempt a strictly lower-priority effect; mute blocks both.
  always_comb begin
    load_s     = 1'b0;
    clr_mask_s = 5'd0;
    if (bus.mute) begin
      load_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      load_s = (hi_id_s != 3'd0);
    end else if (state_r == ST_PLAY) begin
      load_s = (hi_id_s > sfx_id_r);
    end else begin
      load_s = 1'b0;
    end
    if (load_s) begin
      clr_mask_s = 5'd1 << (hi_id_s - 3'd1);
    end else begin
      clr_mask_s = 5'd0;
    end
  end

  // Pending latches: a new pulse wins over the clear of the effect being loaded.
  always_ff @(posedge clk) begin
    if (resetN) begin
      pending_r <= 5'd0;
    end else if (bus.mute) begin
      pending_r <= 5'd0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | ev_s;
    end
  end

  // Playback FSM with registered tone-generator outputs.
  always_ff @(posedge clk) begin
    if (resetN || bus.mute) begin
      state_r     <= ST_IDLE;
      frame_cnt_r <= 4'd0;
      step_r      <= 2'd0;
      tone_en_r   <= 1'b0;
      tone_code_r <= 4'd0;
      sfx_id_r    <= 3'd0;
      busy_r      <= 1'b0;
    end else if (load_s) begin
      // A frame tick coinciding with the load is deliberately not counted.
      state_r     <= ST_PLAY;
      frame_cnt_r <= 4'd0;
      step_r      <= 2'd0;
      tone_en_r   <= 1'b1;
      tone_code_r <= note_of(hi_id_s, 2'd0);
      sfx_id_r    <= hi_id_s;
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
        end
        ST_PLAY: begin
          if (bus.startOfFrame) begin
            if (frame_cnt_r == NOTE_LAST) begin
              frame_cnt_r <= 4'd0;
              if (step_r == last_step_of(sfx_id_r)) begin
                state_r     <= ST_GAP;
                step_r      <= 2'd0;
                tone_en_r   <= 1'b0;
                tone_code_r <= 4'd0;
                sfx_id_r    <= 3'd0;
              end else begin
                step_r      <= step_r + 2'd1;
                tone_code_r <= note_of(sfx_id_r, step_r + 2'd1);
              end
            end else begin
              frame_cnt_r <= frame_cnt_r + 4'd1;
            end
          end else begin
            frame_cnt_r <= frame_cnt_r;
          end
        end
        ST_GAP: begin
          if (bus.startOfFrame) begin
            if (frame_cnt_r == GAP_LAST) begin
              frame_cnt_r <= 4'd0;
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
            end else begin
              frame_cnt_r <= frame_cnt_r + 4'd1;
            end
          end else begin
            frame_cnt_r <= frame_cnt_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          frame_cnt_r <= 4'd0;
          step_r      <= 2'd0;
          tone_en_r   <= 1'b0;
          tone_code_r <= 4'd0;
          sfx_id_r    <= 3'd0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tone_en   = tone_en_r;
  assign bus.tone_code = tone_code_r;
  assign bus.sfx_id    = sfx_id_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed self-checking bench for sfx_scheduler; frames are 4 cycles long,
// inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sfx_scheduler;

  localparam logic [4:0] E_GOLD  = 5'b00001;
  localparam logic [4:0] E_ALIEN = 5'b00010;
  localparam logic [4:0] E_DIED  = 5'b00100;
  localparam logic [4:0] E_WIN   = 5'b01000;
  localparam logic [4:0] E_OVER  = 5'b10000;

  logic clk;
  logic resetN;
  int   cmp_cnt;
  int   err_cnt;

  sfx_scheduler_if bus();

  sfx_scheduler #(.NOTE_FRAMES(4), .GAP_FRAMES(2)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs held for that cycle only.
  task automatic cyc(input logic sof, input logic [4:0] ev, input logic mu);
    bus.startOfFrame = sof;
    {bus.ev_over, bus.ev_win, bus.ev_died, bus.ev_alien, bus.ev_gold} = ev;
    bus.mute = mu;
    @(posedge clk);
    #1;
    bus.startOfFrame = 1'b0;
    {bus.ev_over, bus.ev_win, bus.ev_died, bus.ev_alien, bus.ev_gold} = 5'd0;
    bus.mute = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b1, 5'd0, 1'b0);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_en"},   32'(bus.tone_en),   32'd0);
    check_val({tag, "_code"}, 32'(bus.tone_code), 32'd0);
    check_val({tag, "_id"},   32'(bus.sfx_id),    32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy),      32'd0);
  endtask

  task automatic check_note(input string tag, input int code, input int id);
    check_val({tag, "_en"},   32'(bus.tone_en),   32'd1);
    check_val({tag, "_code"}, 32'(bus.tone_code), code);
    check_val({tag, "_id"},   32'(bus.sfx_id),    id);
    check_val({tag, "_busy"}, 32'(bus.busy),      32'd1);
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    resetN = 1'b1;
    bus.startOfFrame = 1'b0;
    {bus.ev_over, bus.ev_win, bus.ev_died, bus.ev_alien, bus.ev_gold} = 5'd0;
    bus.mute = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_quiet("reset");
    resetN = 1'b0;
    cyc(1'b0, 5'd0, 1'b0);

    // Gold: latency, two notes, gap, idle.
    cyc(1'b0, E_GOLD, 1'b0);
    check_val("gold_lat_en", 32'(bus.tone_en), 32'd0);
    cyc(1'b0, 5'd0, 1'b0);
    check_note("gold_n0", 5, 1);
    frames(3);
    check_val("gold_hold", 32'(bus.tone_code), 32'd5);
    frames(1);
    check_note("gold_n1", 8, 1);
    frames(4);
    check_val("gold_gap_en",   32'(bus.tone_en), 32'd0);
    check_val("gold_gap_busy", 32'(bus.busy),    32'd1);
    check_val("gold_gap_id",   32'(bus.sfx_id),  32'd0);
    frames(1);
    check_val("gold_gap2_busy", 32'(bus.busy), 32'd1);
    frames(1);
    check_quiet("gold_idle");

    // Simultaneous gold + over: over first, gap, then gold.
    cyc(1'b0, E_GOLD | E_OVER, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    check_note("over_n0", 8, 5);
    frames(4);
    check_note("over_n1", 6, 5);
    frames(4);
    check_note("over_n2", 4, 5);
    frames(4);
    check_note("over_n3", 2, 5);
    frames(4);
    check_val("over_gap_en",   32'(bus.tone_en), 32'd0);
    check_val("over_gap_busy", 32'(bus.busy),    32'd1);
    frames(2);
    check_quiet("over_idle");
    cyc(1'b0, 5'd0, 1'b0);
    check_note("after_over_gold", 5, 1);
    frames(4);
    check_note("after_over_gold1", 8, 1);
    frames(6);
    cyc(1'b0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    check_quiet("pend_empty");

    // Alien preempted by died; gold triple pulse plays once afterwards.
    cyc(1'b0, E_ALIEN, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    check_note("alien_n0", 9, 2);
    frames(4);
    check_note("alien_n1", 6, 2);
    cyc(1'b0, E_DIED, 1'b0);
    check_val("preempt_wait", 32'(bus.sfx_id), 32'd2);
    cyc(1'b0, 5'd0, 1'b0);
    check_note("died_n0", 7, 3);
    frames(3);
    check_val("died_timer", 32'(bus.tone_code), 32'd7);
    frames(1);
    check_note("died_n1", 5, 3);
    cyc(1'b0, E_GOLD, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    cyc(1'b0, E_GOLD, 1'b0);
    cyc(1'b0, E_GOLD, 1'b0);
    check_note("died_no_preempt", 5, 3);
    frames(4);
    check_note("died_n2", 3, 3);
    frames(4);
    check_note("died_n3", 1, 3);
    frames(4);
    check_val("died_gap_en",   32'(bus.tone_en), 32'd0);
    check_val("died_gap_busy", 32'(bus.busy),    32'd1);
    frames(2);
    check_quiet("died_idle");
    cyc(1'b0, 5'd0, 1'b0);
    check_note("once_gold", 5, 1);
    frames(10);
    cyc(1'b0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    check_quiet("one_gold_only");

    // Same-id retrigger: no restart, replays after the gap.
    cyc(1'b0, E_GOLD, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    cyc(1'b0, E_GOLD, 1'b0);
    frames(4);
    check_note("retrig_no_restart", 8, 1);
    frames(6);
    check_quiet("retrig_gap_done");
    cyc(1'b0, 5'd0, 1'b0);
    check_note("retrig_replay", 5, 1);

    // Mute with a simultaneous win pulse flushes everything.
    cyc(1'b0, E_WIN, 1'b1);
    check_quiet("mute");
    frames(3);
    check_quiet("mute_after");

    // Reset mid-note with pending bits set.
    cyc(1'b0, E_DIED, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    check_note("pre_rst", 7, 3);
    cyc(1'b0, E_GOLD | E_ALIEN, 1'b0);
    frames(1);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    resetN = 1'b0;
    check_quiet("mid_rst");
    frames(3);
    check_quiet("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
- Shares the single tone generator between the game's sound-effect requests.
- Requests come from game_controller event outputs (gold eaten, alien killed, player died, win, game over). Each request is latched, arbitrated by fixed priority, and played as a short note sequence timed in frames.
- Drives tone_code/tone_en into the audio tone generator.
- Provides preemption, a silence gap between effects, and a global mute.

Parameters:
- NOTE_FRAMES, 4, startOfFrame pulses per note (legal 1..15)
- GAP_FRAMES, 2, startOfFrame pulses of silence after an effect ends (legal 1..15)

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-high reset. Asserted when 1, sampled on rising clk.
- startOfFrame  in  1  one-cycle pulse per frame
- ev_gold  in  1  pulse: player ate gold
- ev_alien  in  1  pulse: alien died
- ev_died  in  1  pulse: player died
- ev_win  in  1  pulse: no diamonds left
- ev_over  in  1  pulse: no lives left
- mute  in  1  level: silence and flush
- tone_en  out  1  tone generator enable
- tone_code  out  4  note index to tone generator
- sfx_id  out  3  effect playing: 0 none, 1 gold, 2 alien, 3 died, 4 win, 5 over
- busy  out  1  1 in PLAY or GAP

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high on resetN.
- Reset: state IDLE; pending cleared. tone_en=0, tone_code=0, sfx_id=0, busy=0. All counters 0. A reset mid-effect aborts it the same edge.
- All outputs are registered.

Pending latches (5 bits, one per event):
- An event pulse sets its bit on the next edge. The bit saturates; repeated pulses do not queue.
- A bit clears on the edge its effect is loaded.
- If set and clear hit the same bit in the same cycle, set wins, so the effect replays once later.

Priority: over(5) > win(4) > died(3) > alien(2) > gold(1).

Note table (tone_code sequence per effect):
- gold: 5,8
- alien: 9,6,3
- died: 7,5,3,1
- win: 1,3,5,8
- over: 8,6,4,2

FSM:
- IDLE:
  - If any pending bit is set and mute=0, load the highest-priority effect: step=0, frame_cnt=0, go to PLAY.
  - On that load edge: tone_en=1, tone_code=note0, sfx_id set, busy=1.
  - Latency: event pulse in cycle t → tone_en=1 in cycle t+2.
- PLAY:
  - Each startOfFrame increments frame_cnt.
  - On the startOfFrame where frame_cnt==NOTE_FRAMES-1: frame_cnt=0 and step advances; tone_code updates on that edge.
  - If the finishing note was the last step: go to GAP with tone_en=0, tone_code=0, sfx_id=0, busy=1.
- GAP:
  - Counts GAP_FRAMES startOfFrame pulses, then goes to IDLE with busy=0.
  - Pending events wait; no preemption in GAP.
- Preemption: in PLAY, if the highest pending priority is strictly greater than sfx_id, reload with the new effect on the next edge (step=0, frame_cnt=0, no gap).
  - Equal or lower priority waits.
  - A same-id retrigger plays after the gap.
- Mute=1:
  - Next edge: state IDLE, pending cleared, all outputs 0.
  - Events are ignored while mute=1.
  - Mute has priority over loading and preemption in the same cycle.
- Simultaneous event pulses: all bits latch; they play in priority order, each followed by a gap.
- startOfFrame in the same cycle as a load is not counted toward the new note.
- Counters are 4-bit; step is 2-bit (max 4 notes); no wrap beyond the table length.

Test Plan:
- Reset, then ev_gold pulse at cycle t → tone_en=1 at t+2 with tone_code=5 and sfx_id=1. After 4 frames tone_code=8. After 8 frames: tone_en=0, busy=1. After 10 frames: busy=0.
- ev_gold and ev_over pulsed in the same cycle → tone_code sequence 8,6,4,2 (sfx_id=5), then a 2-frame gap, then 5,8 (sfx_id=1), then idle with pending empty.
- ev_alien playing at note 6, then ev_died pulse → within 2 cycles tone_code=7, sfx_id=3, note timer restarted. The alien effect is not resumed.
- During ev_died playback, pulse ev_gold three times → after died plus gap, exactly one gold effect plays.
- Effect playing, raise mute for 1 cycle with ev_win pulsed in the same cycle → next edge all outputs 0, state IDLE, nothing plays afterwards.
- Assert resetN=1 for one cycle mid-note with pending bits set → outputs 0, pending cleared, no sound after release.
